pipe_skid_buffer: RTL and testbench



---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_word_reg.sv | 36 +++
 rtl/pipe_skid_buffer.sv | 123 ++++++++++++
 tb/tb_pipe_skid_buffer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid buffer.
package pipe_pkg;

   localparam int unsigned WORD_WIDTH = 32;

   // Buffer fill state; the encoding doubles as the word count.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } state_e;

endpackage

// File: rtl/pipe_word_reg.sv
// Data word register with load enable and asynchronous active-low reset.
module pipe_word_reg
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] word_d;

   // Hold the stored word unless a load is requested.
   always_comb begin
      word_d = word_q;
      if (load) begin
         word_d = d;
      end
   end

   // Word storage, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign q = word_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer between pipeline stages with registered in_ready
// and synchronous flush. All outputs are driven directly from flops.
module pipe_skid_buffer
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   state_e           state_q;
   state_e           state_d;
   logic             in_ready_q;
   logic             in_ready_d;
   logic             out_valid_q;
   logic             out_valid_d;
   logic             accept;
   logic             drain;
   logic             main_load;
   logic             main_from_skid;
   logic             skid_load;
   logic [WIDTH-1:0] main_in;
   logic [WIDTH-1:0] skid_word;

   assign accept = in_valid & in_ready_q;
   assign drain  = out_valid_q & out_ready;

   // Next state and register load controls; flush overrides everything.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_load = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (accept && drain) begin
               main_load = 1'b1;
            end else if (accept) begin
               skid_load = 1'b1;
               state_d   = FULL;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (drain) begin
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               state_d        = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      if (flush) begin
         state_d   = EMPTY;
         main_load = 1'b0;
         skid_load = 1'b0;
      end
      // Handshake outputs are registered from the next state so out_ready
      // never reaches in_ready combinationally.
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   // Control state and registered handshake flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Main register is refilled from the skid word when draining out of FULL.
   always_comb begin
      main_in = in_data;
      if (main_from_skid) begin
         main_in = skid_word;
      end
   end

   pipe_word_reg #(.WIDTH(WIDTH)) u_main (
      .clk   (clk),
      .rst_n (reset),
      .load  (main_load),
      .d     (main_in),
      .q     (out_data)
   );

   pipe_word_reg #(.WIDTH(WIDTH)) u_skid (
      .clk   (clk),
      .rst_n (reset),
      .load  (skid_load),
      .d     (in_data),
      .q     (skid_word)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed bench for pipe_skid_buffer with a queue-based reference model.
module tb_pipe_skid_buffer;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;

   int unsigned total;
   int unsigned bad;

   logic [31:0] mq[$];   // words the buffer must currently hold, head first
   logic [31:0] dq[$];   // words handed downstream, in order

   pipe_skid_buffer #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a bounded FIFO of depth 2, ready whenever not full.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
      end else begin
         automatic int  sz  = mq.size();
         automatic bit  acc = in_valid && (sz < 2);
         automatic bit  drn = (sz > 0) && out_ready;
         if (flush) begin
            mq.delete();
         end else begin
            if (drn) begin
               dq.push_back(mq[0]);
               void'(mq.pop_front());
            end
            if (acc) mq.push_back(in_data);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("model_occupancy", {30'd0, occupancy}, mq.size());
      check("model_out_valid", {31'd0, out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
      check("model_in_ready", {31'd0, in_ready}, (mq.size() < 2) ? 32'd1 : 32'd0);
      if (mq.size() > 0) check("model_out_data", out_data, mq[0]);
   endtask

   // Drive inputs, take one rising edge, then compare on the falling edge.
   task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;

      // Reset then idle
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_occupancy", {30'd0, occupancy}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      compare_model();

      // Single pass with one cycle of latency
      step(1'b1, 32'h0000_00AA, 1'b1, 1'b0);
      check("single_data", out_data, 32'h0000_00AA);
      check("single_valid", {31'd0, out_valid}, 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("single_gone", {31'd0, out_valid}, 32'd0);
      check("single_log", dq[dq.size()-1], 32'h0000_00AA);

      // Backpressure fill, then drain in order
      step(1'b1, 32'h11, 1'b0, 1'b0);
      step(1'b1, 32'h22, 1'b0, 1'b0);
      check("bp_occ", {30'd0, occupancy}, 32'd2);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_head", out_data, 32'h11);
      step(1'b1, 32'h99, 1'b0, 1'b0);   // not accepted while full
      check("bp_hold", out_data, 32'h11);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("bp_second", out_data, 32'h22);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("bp_empty", {30'd0, occupancy}, 32'd0);
      check("bp_order", {dq[dq.size()-2][15:0], dq[dq.size()-1][15:0]}, 32'h0011_0022);

      // Full-rate streaming
      dq.delete();
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, i, 1'b1, 1'b0);
         check("stream_occ", {30'd0, occupancy}, 32'd1);
         check("stream_data", out_data, i);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      begin
         automatic logic [31:0] ok = (dq.size() == 16) ? 32'd1 : 32'd0;
         for (int i = 0; i < dq.size(); i++) if (dq[i] != i + 1) ok = 32'd0;
         check("stream_order", ok, 32'd1);
      end

      // Flush while full, with a word offered
      dq.delete();
      step(1'b1, 32'h33, 1'b0, 1'b0);
      step(1'b1, 32'h44, 1'b0, 1'b0);
      step(1'b1, 32'h55, 1'b0, 1'b1);
      check("flush_occ", {30'd0, occupancy}, 32'd0);
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      // Flush while holding one word and able to accept
      step(1'b1, 32'h66, 1'b0, 1'b0);
      step(1'b1, 32'h77, 1'b1, 1'b1);
      check("flush1_occ", {30'd0, occupancy}, 32'd0);
      repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
      check("flush_nothing_out", dq.size(), 32'd0);

      // Asynchronous reset while full
      step(1'b1, 32'hA1, 1'b0, 1'b0);
      step(1'b1, 32'hA2, 1'b0, 1'b0);
      check("areset_pre_occ", {30'd0, occupancy}, 32'd2);
      #2;
      reset = 1'b0;
      #1;
      check("areset_out_valid", {31'd0, out_valid}, 32'd0);
      check("areset_in_ready", {31'd0, in_ready}, 32'd1);
      check("areset_occ", {30'd0, occupancy}, 32'd0);
      check("areset_data", out_data, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 32'hBEEF, 1'b0, 1'b0);
      check("post_reset_data", out_data, 32'hBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Time bound so the run always terminates.
   initial begin
      #100000;
      bad++;
      $display("FAIL timeout: got no finish expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
